// File: rtl/pr3_pkg.sv
// Shared types and constants for the phase-extraction chain.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package pr3_pkg;

    // Q3.13 phase, range [-pi, pi)
    typedef logic signed [15:0] phase_t;

    // Frequency in Hz, UQ24.0
    typedef logic [23:0] freq_t;

    localparam int PI_Q13     = 25736;
    localparam int TWO_PI_Q13 = 51472;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_EMIT
    } state_t;

    // Bin index to Hz: full 64-bit product, shifted by log2(frame length), truncated to 24 bits
    function automatic freq_t bin_to_hz(input logic [31:0] bin, input int fs, input int shift);
        logic [63:0] prod;
        prod = {32'd0, bin} * {32'd0, 32'(fs)};
        return freq_t'(prod >> shift);
    endfunction

endpackage

// File: rtl/phase_wrap.sv
// Wrapped phase difference a-b, folded back into [-pi, pi] in Q3.13.
// Latency: 1 cycle (single registered stage).
// Backpressure: none, a new pair is accepted every cycle.
module phase_wrap
    import pr3_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  phase_t i_a,
    input  phase_t i_b,
    output phase_t o_diff
);

    // One extra bit so the raw difference of two Q3.13 values never overflows
    logic signed [16:0] w_diff;
    phase_t             r_diff;

    assign w_diff = 17'(i_a) - 17'(i_b);
    assign o_diff = r_diff;

    // Fold the raw difference by one full turn when it leaves [-pi, pi]
    always_ff @(posedge clk) begin
        if (reset) begin
            r_diff <= '0;
        end else if (w_diff > PI_Q13) begin
            r_diff <= phase_t'(32'(w_diff) - TWO_PI_Q13);
        end else if (w_diff < -PI_Q13) begin
            r_diff <= phase_t'(32'(w_diff) + TWO_PI_Q13);
        end else begin
            r_diff <= phase_t'(w_diff);
        end
    end

endmodule

// File: rtl/peak_phase_detect.sv
// Finds channel-0 peak bin per run of NCHAN FFT frames and reports each channel's phase relative to channel 0.
// Latency: first record 2 cycles after the final eop beat, then one record per cycle (chan 1..NCHAN-1).
// Backpressure: none; input accepted every cycle, downstream must take every record.
module peak_phase_detect
    import pr3_pkg::*;
#(
    parameter int NCHAN   = 3,
    parameter int FFT     = 11,
    parameter int MWIDTH  = 25,
    parameter int FS      = 20000000,
    parameter int BIN_MIN = 1,
    parameter int BIN_MAX = 2**(FFT-1)-1,
    parameter int MAG_MIN = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      sink_valid,
    input  logic                      sink_sop,
    input  logic                      sink_eop,
    input  logic [MWIDTH-1:0]         sink_mag,
    input  phase_t                    sink_phase,
    output logic                      source_valid,
    output logic                      source_sop,
    output logic                      source_eop,
    output logic [$clog2(NCHAN)-1:0]  source_chan,
    output freq_t                     source_freq,
    output phase_t                    source_phase,
    output logic                      source_lock,
    output logic                      source_error
);

    localparam int CW = $clog2(NCHAN);
    localparam logic [FFT-1:0] LAST_BIN = {FFT{1'b1}};

    // Control / counters
    state_t            r_state;
    logic [FFT-1:0]    r_bin_nxt;      // bin number the next non-sop beat will carry
    logic              r_in_frame;
    logic [CW-1:0]     r_chan;
    logic              r_bad;

    // Peak search and per-channel capture for the run in progress
    logic [MWIDTH-1:0] r_peak_mag;
    logic [FFT-1:0]    r_peak_bin;
    phase_t            r_ref_phase;
    phase_t            r_cap [NCHAN];  // entry 0 unused; kept so chan indexes directly

    // Snapshot of a finished run, so the next run can capture freely while this one is emitted
    freq_t             r_em_freq;
    phase_t            r_em_ref;
    phase_t            r_em_ph [NCHAN];
    logic              r_em_lock;
    logic [CW-1:0]     r_emit_idx;

    // Registered outputs
    logic              r_valid;
    logic              r_sop;
    logic              r_eop;
    logic [CW-1:0]     r_out_chan;
    freq_t             r_freq;
    logic              r_lock;
    logic              r_error;

    logic              w_beat;
    logic [FFT-1:0]    w_bin;
    logic              w_last_chan;
    logic              w_run_end;
    logic              w_err;
    logic              w_in_win;
    logic              w_ch0_sop;
    logic [MWIDTH-1:0] w_peak_ref;
    logic              w_peak_upd;
    logic              w_cap_hit;
    phase_t            w_wrap_diff;

    // Beats before the first sop after reset are ignored
    assign w_beat      = sink_valid && (r_state != ST_IDLE || sink_sop);
    assign w_bin       = sink_sop ? '0 : r_bin_nxt;
    assign w_last_chan = (r_chan == CW'(NCHAN-1));
    assign w_run_end   = w_beat && sink_eop && w_last_chan;
    assign w_err       = w_beat && ((sink_sop && r_in_frame) || (sink_eop && (w_bin != LAST_BIN)));
    assign w_in_win    = (int'(w_bin) >= BIN_MIN) && (int'(w_bin) <= BIN_MAX);
    assign w_ch0_sop   = w_beat && sink_sop && (r_chan == '0);
    // The channel-0 sop beat compares against a freshly cleared peak
    assign w_peak_ref  = w_ch0_sop ? '0 : r_peak_mag;
    assign w_peak_upd  = w_beat && (r_chan == '0) && w_in_win && (sink_mag > w_peak_ref);
    assign w_cap_hit   = w_beat && (r_chan != '0) && (w_bin == r_peak_bin);

    // Bin counter, channel counter, frame tracking and bad-run flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bin_nxt  <= '0;
            r_in_frame <= 1'b0;
            r_chan     <= '0;
            r_bad      <= 1'b0;
        end else if (w_beat) begin
            r_bin_nxt  <= w_bin + FFT'(1);
            r_in_frame <= !sink_eop;
            if (sink_eop) begin
                r_chan <= w_last_chan ? '0 : r_chan + CW'(1);
            end
            // Any error at the final eop is folded into the snapshot, so the flag restarts clean
            if (w_run_end) begin
                r_bad <= 1'b0;
            end else if (w_err) begin
                r_bad <= 1'b1;
            end
        end
    end

    // Channel-0 peak search (strict compare keeps the lowest bin on ties) and phase capture for k>0
    always_ff @(posedge clk) begin
        if (reset) begin
            r_peak_mag  <= '0;
            r_peak_bin  <= '0;
            r_ref_phase <= '0;
            for (int k = 0; k < NCHAN; k++) begin
                r_cap[k] <= '0;
            end
        end else begin
            if (w_peak_upd) begin
                r_peak_mag  <= sink_mag;
                r_peak_bin  <= w_bin;
                r_ref_phase <= sink_phase;
            end else if (w_ch0_sop) begin
                // Clearing bin and reference too keeps a no-peak run from reusing the previous run's bin
                r_peak_mag  <= '0;
                r_peak_bin  <= '0;
                r_ref_phase <= '0;
            end
            if (w_cap_hit) begin
                r_cap[r_chan] <= sink_phase;
            end
        end
    end

    // Snapshot the finished run on its final eop beat, forwarding a capture that lands on that same beat
    always_ff @(posedge clk) begin
        if (reset) begin
            r_em_freq <= '0;
            r_em_ref  <= '0;
            r_em_lock <= 1'b0;
            for (int k = 0; k < NCHAN; k++) begin
                r_em_ph[k] <= '0;
            end
        end else if (w_run_end) begin
            r_em_freq <= bin_to_hz(32'(r_peak_bin), FS, FFT);
            r_em_ref  <= r_ref_phase;
            r_em_lock <= (r_peak_mag > MWIDTH'(MAG_MIN)) && !r_bad && !w_err;
            for (int k = 0; k < NCHAN; k++) begin
                r_em_ph[k] <= (w_cap_hit && (r_chan == CW'(k))) ? sink_phase : r_cap[k];
            end
        end
    end

    // Run FSM and record sideband; the wrap stage produces the phase in step with these registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_emit_idx <= '0;
            r_valid    <= 1'b0;
            r_sop      <= 1'b0;
            r_eop      <= 1'b0;
            r_out_chan <= '0;
            r_freq     <= '0;
            r_lock     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
            r_error <= w_err;
            case (r_state)
                ST_IDLE: begin
                    if (sink_valid && sink_sop) begin
                        r_state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    r_state <= ST_SCAN;
                end
                ST_EMIT: begin
                    r_valid    <= 1'b1;
                    r_out_chan <= r_emit_idx;
                    r_sop      <= (r_emit_idx == CW'(1));
                    r_eop      <= (r_emit_idx == CW'(NCHAN-1));
                    r_freq     <= r_em_freq;
                    r_lock     <= r_em_lock;
                    if (r_emit_idx == CW'(NCHAN-1)) begin
                        r_state <= ST_SCAN;
                    end else begin
                        r_emit_idx <= r_emit_idx + CW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
            // A run end always (re)starts emission of the newest snapshot
            if (w_run_end) begin
                r_state    <= ST_EMIT;
                r_emit_idx <= CW'(1);
            end
        end
    end

    phase_wrap u_wrap (
        .clk    (clk),
        .reset  (reset),
        .i_a    (r_em_ph[r_emit_idx]),
        .i_b    (r_em_ref),
        .o_diff (w_wrap_diff)
    );

    assign source_valid = r_valid;
    assign source_sop   = r_sop;
    assign source_eop   = r_eop;
    assign source_chan  = r_out_chan;
    assign source_freq  = r_freq;
    assign source_phase = w_wrap_diff;
    assign source_lock  = r_lock;
    assign source_error = r_error;

endmodule

// File: tb/tb_peak_phase_detect.sv
// Scoreboard bench for peak_phase_detect: default 3-channel build plus a 4-channel FFT=6 build.
// Latency: expected records are queued at stimulus time and checked whenever source_valid is seen.
// Backpressure: none; records are consumed every cycle.
module tb_peak_phase_detect;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 3-channel build
    logic        i3_valid = 0, i3_sop = 0, i3_eop = 0;
    logic [24:0] i3_mag = '0;
    logic [15:0] i3_phase = '0;
    logic        o3_valid, o3_sop, o3_eop, o3_lock, o3_error;
    logic [1:0]  o3_chan;
    logic [23:0] o3_freq;
    logic [15:0] o3_phase;

    // 4-channel, 64-bin build
    logic        i4_valid = 0, i4_sop = 0, i4_eop = 0;
    logic [24:0] i4_mag = '0;
    logic [15:0] i4_phase = '0;
    logic        o4_valid, o4_sop, o4_eop, o4_lock, o4_error;
    logic [1:0]  o4_chan;
    logic [23:0] o4_freq;
    logic [15:0] o4_phase;

    peak_phase_detect dut3 (
        .clk(clk), .reset(reset),
        .sink_valid(i3_valid), .sink_sop(i3_sop), .sink_eop(i3_eop),
        .sink_mag(i3_mag), .sink_phase(i3_phase),
        .source_valid(o3_valid), .source_sop(o3_sop), .source_eop(o3_eop),
        .source_chan(o3_chan), .source_freq(o3_freq), .source_phase(o3_phase),
        .source_lock(o3_lock), .source_error(o3_error)
    );

    peak_phase_detect #(.NCHAN(4), .FFT(6)) dut4 (
        .clk(clk), .reset(reset),
        .sink_valid(i4_valid), .sink_sop(i4_sop), .sink_eop(i4_eop),
        .sink_mag(i4_mag), .sink_phase(i4_phase),
        .source_valid(o4_valid), .source_sop(o4_sop), .source_eop(o4_eop),
        .source_chan(o4_chan), .source_freq(o4_freq), .source_phase(o4_phase),
        .source_lock(o4_lock), .source_error(o4_error)
    );

    typedef struct {
        int chan; int freq; int phase;
        bit lock; bit sop; bit eop; bit fdc;
    } rec_t;
    typedef struct { int b; int m; int p; } sp_t;

    rec_t q3[$];
    rec_t q4[$];
    sp_t  sp_q[$];
    int   fm [2048];
    int   fp [2048];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   err_cnt = 0;
    int   eop_cyc = 0;
    int   sop_cyc = 0;

    task automatic chk(input string nm, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", nm, got, exp);
        end
    endtask

    task automatic cmp_rec(input string nm, input bit have, input rec_t e, input int ch, input int fr,
                           input int ph, input bit lk, input bit sp, input bit ep);
        n_tests++;
        if (!have) begin
            n_fail++;
            $display("FAIL %s unexpected record: chan=%0d freq=%0d phase=%0d lock=%0d (none queued)",
                     nm, ch, fr, ph, lk);
        end else if (ch != e.chan || (!e.fdc && fr != e.freq) || ph != e.phase ||
                     lk != e.lock || sp != e.sop || ep != e.eop) begin
            n_fail++;
            $display("FAIL %s record: got chan=%0d freq=%0d phase=%0d lock=%0d sop=%0d eop=%0d, required chan=%0d freq=%0d phase=%0d lock=%0d sop=%0d eop=%0d",
                     nm, ch, fr, ph, lk, sp, ep, e.chan, e.freq, e.phase, e.lock, e.sop, e.eop);
        end
    endtask

    task automatic ex(input bit d4, input int ch, input int fr, input int ph, input bit lk,
                      input bit sp, input bit ep, input bit fdc);
        rec_t r;
        r.chan = ch; r.freq = fr; r.phase = ph; r.lock = lk; r.sop = sp; r.eop = ep; r.fdc = fdc;
        if (d4) q4.push_back(r); else q3.push_back(r);
    endtask

    // Monitors: pop and compare whenever a record appears
    always @(negedge clk) begin
        rec_t e;
        bit   have;
        if (o3_valid === 1'b1) begin
            have = (q3.size() != 0);
            e = '{default: 0};
            if (have) e = q3.pop_front();
            if (o3_sop) sop_cyc = cyc;
            cmp_rec("dut3", have, e, int'(o3_chan), int'(o3_freq), int'($signed(o3_phase)),
                    o3_lock, o3_sop, o3_eop);
        end
        if (o4_valid === 1'b1) begin
            have = (q4.size() != 0);
            e = '{default: 0};
            if (have) e = q4.pop_front();
            cmp_rec("dut4", have, e, int'(o4_chan), int'(o4_freq), int'($signed(o4_phase)),
                    o4_lock, o4_sop, o4_eop);
        end
        if (o3_error === 1'b1) err_cnt++;
    end

    task automatic drive(input bit d4, input bit v, input bit s, input bit e, input int m, input int p);
        if (d4) begin
            i4_valid = v; i4_sop = s; i4_eop = e; i4_mag = 25'(m); i4_phase = 16'(p);
        end else begin
            i3_valid = v; i3_sop = s; i3_eop = e; i3_mag = 25'(m); i3_phase = 16'(p);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            drive(0, 0, 0, 0, 0, 0);
            drive(1, 0, 0, 0, 0, 0);
        end
    endtask

    task automatic sp(input int b, input int m, input int p);
        sp_t s;
        s.b = b; s.m = m; s.p = p;
        sp_q.push_back(s);
    endtask

    // One frame of bins 0..last (eop on last); queued specials override the default mag / zero phase
    task automatic frame(input bit d4, input int last, input int dmag, input bit gap);
        for (int i = 0; i < 2048; i++) begin
            fm[i] = dmag; fp[i] = 0;
        end
        foreach (sp_q[j]) begin
            fm[sp_q[j].b] = sp_q[j].m;
            fp[sp_q[j].b] = sp_q[j].p;
        end
        sp_q.delete();
        for (int i = 0; i <= last; i++) begin
            @(posedge clk); #1;
            if (gap && i == 500) begin
                drive(d4, 0, 0, 0, 0, 0);
                @(posedge clk); #1;
            end
            drive(d4, 1, i == 0, i == last, fm[i], fp[i]);
            if (i == last && !d4) eop_cyc = cyc;
        end
    endtask

    // Three-channel run: peak (pb,pm) in ch0 with ref p0; ch1/ch2 phases p1/p2 at pb
    task automatic run3(input int pb, input int pm, input int p0, input int p1, input int p2,
                        input int ch1_last, input bit gap);
        sp(pb, pm, p0);
        frame(0, 2047, 10, gap);
        sp(pb, 10, p1);
        frame(0, ch1_last, 10, 0);
        sp(pb, 10, p2);
        frame(0, 2047, 10, 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, o3_valid, 0);
        chk({tag, "_sop"},   o3_sop,   0);
        chk({tag, "_eop"},   o3_eop,   0);
        chk({tag, "_chan"},  o3_chan,  0);
        chk({tag, "_freq"},  o3_freq,  0);
        chk({tag, "_phase"}, o3_phase, 0);
        chk({tag, "_lock"},  o3_lock,  0);
        chk({tag, "_error"}, o3_error, 0);
    endtask

    initial begin
        int e0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk_zero("reset");

        // Stray beats before any sop must be ignored (would otherwise advance chan / flag an error)
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            drive(0, 1, 0, i == 4, 25'h1FFFFFF, 0);
        end
        idle(3);

        // 1: basic run, 976562 Hz, phases 24000 and 25472 (wrapped), with a valid gap in ch0
        ex(0, 1, 976562, 24000, 1, 1, 0, 0);
        ex(0, 2, 976562, 25472, 1, 0, 1, 0);
        run3(100, 500, 1000, 25000, -25000, 2047, 1);
        idle(6);
        chk("latency_eop_to_valid", sop_cyc - eop_cyc, 2);
        chk("no_error_clean", err_cnt, 0);

        // 2: tie at bins 40/80 -> 40 wins; bins 0 and 1024 are outside the window
        ex(0, 1, 390625, 5000, 1, 1, 0, 0);
        ex(0, 2, 390625, -19472, 1, 0, 1, 0);
        sp(80, 300, 0);
        sp(0, 900, 0);
        sp(1024, 900, 0);
        run3(40, 300, -2000, 3000, 30000, 2047, 0);
        idle(6);

        // 3: short ch1 frame -> one error pulse, lock=0; following clean run locks again
        e0 = err_cnt;
        ex(0, 1, 976562, 24000, 0, 1, 0, 0);
        ex(0, 2, 976562, 25472, 0, 0, 1, 0);
        run3(100, 500, 1000, 25000, -25000, 1000, 0);
        ex(0, 1, 976562, 24000, 1, 1, 0, 0);
        ex(0, 2, 976562, 25472, 1, 0, 1, 0);
        run3(100, 500, 1000, 25000, -25000, 2047, 0);
        idle(6);
        chk("error_pulse_count", err_cnt - e0, 1);

        // 4: reset right after the chan1 record -> chan2 never appears, outputs zero
        ex(0, 1, 976562, 24000, 1, 1, 0, 0);
        run3(100, 500, 1000, 25000, -25000, 2047, 0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk_zero("reset_emit");
        idle(3);

        // 5: back-to-back runs with different peaks, then a run with no magnitude at all
        ex(0, 1, 976562, 24000, 1, 1, 0, 0);
        ex(0, 2, 976562, 25472, 1, 0, 1, 0);
        ex(0, 1, 390625, 5000, 1, 1, 0, 0);
        ex(0, 2, 390625, -19472, 1, 0, 1, 0);
        run3(100, 500, 1000, 25000, -25000, 2047, 0);
        run3(40, 300, -2000, 3000, 30000, 2047, 0);
        ex(0, 1, 0, 0, 0, 1, 0, 1);
        ex(0, 2, 0, 0, 0, 0, 1, 1);
        frame(0, 2047, 0, 0);
        frame(0, 2047, 0, 0);
        frame(0, 2047, 0, 0);
        idle(6);

        // 6: 4-channel build, 10*FS>>6 = 3125000 Hz; ch3 -20000 vs ref 20000 wraps to 11472
        ex(1, 1, 3125000, 0, 1, 1, 0, 0);
        ex(1, 2, 3125000, -20000, 1, 0, 0, 0);
        ex(1, 3, 3125000, 11472, 1, 0, 1, 0);
        sp(10, 500, 20000);
        frame(1, 63, 10, 0);
        sp(10, 10, 20000);
        frame(1, 63, 10, 0);
        sp(10, 10, 0);
        frame(1, 63, 10, 0);
        sp(10, 10, -20000);
        frame(1, 63, 10, 0);
        idle(8);

        for (int i = 0; i < 200 && (q3.size() != 0 || q4.size() != 0); i++) @(negedge clk);
        chk("drain_dut3", q3.size(), 0);
        chk("drain_dut4", q4.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "time limit");
    end

endmodule
